fetch_issue_queue: RTL and testbench

- Parametrised multi-issue instruction queue between the IF and ID stages of the pipelined MIPS core.
- Replaces the fixed two-instruction IF/ID hand-off with a circular buffer.
- Accepts up to FETCH_W instructions per cycle from instruction memory and presents up to ISSUE_W in program order to decode.
- Supports stall, single-issue and full-width consumption, plus a one-cycle flush on taken branch.

---
 rtl/fiq_pkg.sv | 22 ++
 rtl/fetch_issue_queue_if.sv | 34 +++
 rtl/fiq_ring_ram.sv | 34 +++
 rtl/fetch_issue_queue.sv | 116 +++++++++++
 tb/tb_fetch_issue_queue.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/fiq_pkg.sv
// rtl/fiq_pkg.sv - shared constants and width helpers for the fetch/issue queue
package fiq_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int          PC_STEP   = 4;

    // Width of a counter that must hold 0..n inclusive
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Width of a pointer into a ring of depth entries
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width of an occupancy counter for a ring of depth entries
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_issue_queue_if.sv
// rtl/fetch_issue_queue_if.sv - fetch and issue handshake bundle of the IF/ID queue
interface fetch_issue_queue_if
    import fiq_pkg::*;
#(
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    parameter int DEPTH   = 8,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32
);
    logic                         fetch_valid;
    logic [cnt_w(FETCH_W)-1:0]    fetch_count;
    logic [FETCH_W*DATA_W-1:0]    fetch_instr;
    logic [ADDR_W-1:0]            fetch_pc;
    logic                         fetch_ready;
    logic [cnt_w(ISSUE_W)-1:0]    issue_max;
    logic [cnt_w(ISSUE_W)-1:0]    issue_count;
    logic [ISSUE_W*DATA_W-1:0]    issue_instr;
    logic [ISSUE_W*ADDR_W-1:0]    issue_pc;
    logic                         flush;
    logic [occ_w(DEPTH)-1:0]      occupancy;
    logic                         protocol_err;

    modport master (
        output fetch_valid, fetch_count, fetch_instr, fetch_pc, issue_max, flush,
        input  fetch_ready, issue_count, issue_instr, issue_pc, occupancy, protocol_err
    );

    modport slave (
        input  fetch_valid, fetch_count, fetch_instr, fetch_pc, issue_max, flush,
        output fetch_ready, issue_count, issue_instr, issue_pc, occupancy, protocol_err
    );

endinterface

// File: rtl/fiq_ring_ram.sv
// rtl/fiq_ring_ram.sv - multi-write, multi-read ring storage for queue entries
module fiq_ring_ram #(
    parameter int DEPTH = 8,
    parameter int PW    = 3,
    parameter int EW    = 64,
    parameter int WR_N  = 2,
    parameter int RD_N  = 2
) (
    input  logic                      CLK,
    input  logic [WR_N-1:0]           we,
    input  logic [WR_N-1:0][PW-1:0]   waddr,
    input  logic [WR_N-1:0][EW-1:0]   wdata,
    input  logic [RD_N-1:0][PW-1:0]   raddr,
    output logic [RD_N-1:0][EW-1:0]   rdata
);
    logic [EW-1:0] mem [DEPTH];

    // Write every enabled slot; the queue guarantees the addresses are distinct
    always_ff @(posedge CLK) begin
        for (int i = 0; i < WR_N; i++) begin
            if (we[i]) begin
                mem[waddr[i]] <= wdata[i];
            end
        end
    end

    // Combinational read ports, one per issue slot
    always_comb begin
        for (int j = 0; j < RD_N; j++) begin
            rdata[j] = mem[raddr[j]];
        end
    end

endmodule

// File: rtl/fetch_issue_queue.sv
// rtl/fetch_issue_queue.sv - circular multi-issue instruction queue between IF and ID
module fetch_issue_queue
    import fiq_pkg::*;
#(
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    parameter int DEPTH   = 8,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32
) (
    input  logic               CLK,
    input  logic               RESET,
    fetch_issue_queue_if.slave bus
);
    localparam int PW  = ptr_w(DEPTH);
    localparam int OW  = occ_w(DEPTH);
    localparam int FCW = cnt_w(FETCH_W);
    localparam int ICW = cnt_w(ISSUE_W);
    localparam int EW  = DATA_W + ADDR_W;

    logic [PW-1:0]                head;
    logic [PW-1:0]                tail;
    logic [OW-1:0]                occ;
    logic                         err;
    logic                         ready;
    logic                         count_ok;
    logic                         push;
    logic [FCW-1:0]               push_n;
    logic [ICW-1:0]               issue_cnt;
    logic [ICW-1:0]               max_c;
    logic [ICW-1:0]               pop_n;
    logic [FETCH_W-1:0]           we;
    logic [FETCH_W-1:0][PW-1:0]   waddr;
    logic [FETCH_W-1:0][EW-1:0]   wdata;
    logic [ISSUE_W-1:0][PW-1:0]   raddr;
    logic [ISSUE_W-1:0][EW-1:0]   rdata;

    // Flow control: readiness from registered occupancy only, pop clamped to what is visible
    always_comb begin
        ready     = (32'(DEPTH) - 32'(occ)) >= 32'(FETCH_W);
        count_ok  = (bus.fetch_count != '0) && (32'(bus.fetch_count) <= 32'(FETCH_W));
        push      = bus.fetch_valid && ready && count_ok && !bus.flush;
        push_n    = push ? bus.fetch_count : '0;
        issue_cnt = (32'(occ) >= 32'(ISSUE_W)) ? ICW'(ISSUE_W) : ICW'(occ);
        max_c     = (32'(bus.issue_max) > 32'(ISSUE_W)) ? ICW'(ISSUE_W) : bus.issue_max;
        pop_n     = bus.flush ? '0 : ((max_c < issue_cnt) ? max_c : issue_cnt);
    end

    // Scatter the fetch bundle into consecutive ring slots starting at tail
    always_comb begin
        for (int i = 0; i < FETCH_W; i++) begin
            we[i]    = push && (32'(i) < 32'(bus.fetch_count));
            waddr[i] = tail + PW'(i);
            wdata[i] = {bus.fetch_instr[i*DATA_W +: DATA_W],
                        bus.fetch_pc + ADDR_W'(PC_STEP * i)};
        end
    end

    // Issue slots read the oldest entries; slots past the valid count show a NOP at pc 0
    always_comb begin
        bus.issue_instr = '0;
        bus.issue_pc    = '0;
        for (int j = 0; j < ISSUE_W; j++) begin
            raddr[j] = head + PW'(j);
            bus.issue_instr[j*DATA_W +: DATA_W] = DATA_W'(NOP_INSTR);
            if (32'(j) < 32'(issue_cnt)) begin
                bus.issue_instr[j*DATA_W +: DATA_W] = rdata[j][EW-1 -: DATA_W];
                bus.issue_pc[j*ADDR_W +: ADDR_W]    = rdata[j][ADDR_W-1:0];
            end
        end
    end

    assign bus.fetch_ready  = ready;
    assign bus.issue_count  = issue_cnt;
    assign bus.occupancy    = occ;
    assign bus.protocol_err = err;

    // Pointer and occupancy update; flush empties the queue, the error flag is sticky
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
            err  <= 1'b0;
        end else begin
            if (bus.flush) begin
                head <= '0;
                tail <= '0;
                occ  <= '0;
            end else begin
                head <= head + PW'(pop_n);
                tail <= tail + PW'(push_n);
                occ  <= occ + OW'(push_n) - OW'(pop_n);
            end
            if (bus.fetch_valid && (!count_ok || !ready)) begin
                err <= 1'b1;
            end
        end
    end

    fiq_ring_ram #(
        .DEPTH (DEPTH),
        .PW    (PW),
        .EW    (EW),
        .WR_N  (FETCH_W),
        .RD_N  (ISSUE_W)
    ) u_ram (
        .CLK   (CLK),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_fetch_issue_queue.sv
// tb/tb_fetch_issue_queue.sv - randomized scoreboard bench for fetch_issue_queue
module tb_fetch_issue_queue;
    localparam int FW = 2;
    localparam int IW = 2;
    localparam int D  = 8;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    fetch_issue_queue_if #(.FETCH_W(FW), .ISSUE_W(IW), .DEPTH(D), .DATA_W(32), .ADDR_W(32)) bus ();

    fetch_issue_queue #(.FETCH_W(FW), .ISSUE_W(IW), .DEPTH(D), .DATA_W(32), .ADDR_W(32)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    ent_t mq[$];
    ent_t scb[$];
    int   exp_cnt_q[$];
    bit   m_err;
    bit   mon_en;
    int   vectors;
    int   errors;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.fetch_valid = 1'b0;
        bus.fetch_count = '0;
        bus.fetch_instr = '0;
        bus.fetch_pc    = '0;
        bus.issue_max   = '0;
        bus.flush       = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_occupancy"}, 64'(bus.occupancy), 0);
        chk({tag, "_issue_count"}, 64'(bus.issue_count), 0);
        chk({tag, "_issue_instr"}, 64'(bus.issue_instr), 0);
        chk({tag, "_issue_pc"}, 64'(bus.issue_pc), 0);
        chk({tag, "_fetch_ready"}, 64'(bus.fetch_ready), 1);
        chk({tag, "_protocol_err"}, 64'(bus.protocol_err), 0);
    endtask

    // One cycle: apply inputs, predict from the reference queue, advance to just after the edge
    task automatic step(input bit fv, input int fc, input logic [31:0] pc, input int im, input bit fl);
        int   size;
        bit   rdy;
        int   icnt;
        int   pop;
        int   imc;
        bit   ok;
        ent_t e;
        bus.fetch_valid = fv;
        bus.fetch_count = 2'(fc);
        bus.fetch_pc    = pc;
        for (int s = 0; s < FW; s++) bus.fetch_instr[s*32 +: 32] = $urandom;
        bus.issue_max   = 2'(im);
        bus.flush       = fl;

        size = mq.size();
        rdy  = (D - size) >= FW;
        chk("occupancy", 64'(bus.occupancy), 64'(size));
        chk("fetch_ready", 64'(bus.fetch_ready), 64'(rdy));
        chk("protocol_err", 64'(bus.protocol_err), 64'(m_err));

        icnt = (size < IW) ? size : IW;
        imc  = (im > IW) ? IW : im;
        pop  = (imc < icnt) ? imc : icnt;
        ok   = (fc >= 1) && (fc <= FW);
        exp_cnt_q.push_back(icnt);
        if (fv && (!ok || !rdy)) m_err = 1'b1;
        if (fl) begin
            mq.delete();
        end else begin
            for (int k = 0; k < pop; k++) scb.push_back(mq.pop_front());
            if (fv && ok && rdy) begin
                for (int k = 0; k < fc; k++) begin
                    e.instr = bus.fetch_instr[k*32 +: 32];
                    e.pc    = pc + 32'(4 * k);
                    mq.push_back(e);
                end
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic async_reset();
        mon_en = 1'b0;
        drive_idle();
        RESET = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        mq.delete();
        m_err = 1'b0;
        @(posedge CLK);
        #1;
        RESET  = 1'b1;
        mon_en = 1'b1;
    endtask

    // Monitor: compare consumed issue slots against the scoreboard in the middle of each cycle
    always @(negedge CLK) begin
        if (mon_en && exp_cnt_q.size() > 0) begin
            int   ec;
            int   im;
            int   n;
            ent_t e;
            ec = exp_cnt_q.pop_front();
            chk("issue_count", 64'(bus.issue_count), 64'(ec));
            im = int'(bus.issue_max);
            if (im > IW) im = IW;
            n = (im < int'(bus.issue_count)) ? im : int'(bus.issue_count);
            if (!bus.flush) begin
                for (int j = 0; j < n; j++) begin
                    if (scb.size() == 0) begin
                        chk("scb_underflow", 64'(j), 64'hFFFF);
                    end else begin
                        e = scb.pop_front();
                        chk("issue_instr", 64'(bus.issue_instr[j*32 +: 32]), 64'(e.instr));
                        chk("issue_pc", 64'(bus.issue_pc[j*32 +: 32]), 64'(e.pc));
                    end
                end
            end
            for (int j = int'(bus.issue_count); j < IW; j++) begin
                chk("empty_slot_instr", 64'(bus.issue_instr[j*32 +: 32]), 0);
                chk("empty_slot_pc", 64'(bus.issue_pc[j*32 +: 32]), 0);
            end
        end
    end

    initial begin
        int   fv;
        int   fc;
        int   im;
        bit   fl;
        logic [31:0] rpc;
        vectors = 0;
        errors  = 0;
        m_err   = 1'b0;
        mon_en  = 1'b0;
        drive_idle();
        repeat (2) @(posedge CLK);
        #1;
        check_reset_outputs("reset");
        RESET  = 1'b1;
        mon_en = 1'b1;

        // Full-rate stream, two in and two out per cycle
        for (int k = 0; k < 8; k++) step(1, 2, 32'h100 + 32'(8 * k), 2, 0);
        chk("stream_occ", 64'(bus.occupancy), 2);
        chk("stream_pc0", 64'(bus.issue_pc[31:0]), 64'h138);
        chk("stream_pc1", 64'(bus.issue_pc[63:32]), 64'h13C);
        repeat (2) step(0, 0, 0, 2, 0);

        // Partial bundle
        step(1, 1, 32'h200, 0, 0);
        chk("partial_occ", 64'(bus.occupancy), 1);
        chk("partial_pc", 64'(bus.issue_pc[31:0]), 64'h200);
        step(1, 2, 32'h210, 2, 0);
        step(1, 2, 32'h220, 2, 0);
        step(0, 0, 0, 2, 0);

        // Single issue across the head wrap
        for (int k = 0; k < 10; k++) begin
            if (k < 3) step(1, 2, 32'h300 + 32'(8 * k), 1, 0);
            else       step(0, 0, 0, 1, 0);
        end
        repeat (2) step(0, 0, 0, 2, 0);

        // Flush with simultaneous push and pop
        step(1, 2, 32'h500, 0, 0);
        step(1, 2, 32'h508, 0, 0);
        chk("preflush_occ", 64'(bus.occupancy), 4);
        step(1, 2, 32'h510, 2, 1);
        chk("flush_occ", 64'(bus.occupancy), 0);
        step(1, 2, 32'h400, 0, 0);
        chk("postflush_pc0", 64'(bus.issue_pc[31:0]), 64'h400);
        chk("postflush_pc1", 64'(bus.issue_pc[63:32]), 64'h404);
        step(0, 0, 0, 2, 0);

        // Fill with ID stalled, then push while full
        for (int k = 0; k < 4; k++) step(1, 2, 32'h600 + 32'(8 * k), 0, 0);
        chk("fill_occ", 64'(bus.occupancy), 8);
        chk("fill_ready", 64'(bus.fetch_ready), 0);
        step(1, 2, 32'h620, 0, 0);
        chk("overflow_occ", 64'(bus.occupancy), 8);
        chk("overflow_err", 64'(bus.protocol_err), 1);

        // Asynchronous reset with entries in flight
        async_reset();
        step(1, 2, 32'h700, 0, 0);
        step(1, 2, 32'h708, 0, 0);
        step(1, 1, 32'h710, 0, 0);
        chk("prereset_occ", 64'(bus.occupancy), 5);
        async_reset();

        // Oversized bundle count
        step(1, 3, 32'h800, 0, 0);
        chk("badcount_occ", 64'(bus.occupancy), 0);
        chk("badcount_err", 64'(bus.protocol_err), 1);
        async_reset();

        // Randomized traffic
        rpc = 32'h1000;
        for (int k = 0; k < 400; k++) begin
            bit mrdy;
            mrdy = (D - mq.size()) >= FW;
            fv = ($urandom_range(0, 3) != 0) && (mrdy || $urandom_range(0, 49) == 0);
            fc = ($urandom_range(0, 99) == 0) ? $urandom_range(0, 3) : $urandom_range(1, 2);
            im = $urandom_range(0, 3);
            fl = ($urandom_range(0, 15) == 0);
            if (fl && (!mrdy || fc < 1 || fc > FW)) fv = 0;
            step(fv[0], fc, rpc, im, fl);
            if (fv != 0) rpc = rpc + 32'h20;
        end
        for (int k = 0; k < 6; k++) step(0, 0, 0, 2, 0);
        chk("drain_occ", 64'(bus.occupancy), 0);
        chk("scb_drain", 64'(scb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
